// File: rtl/inv_mixcolumn_subbyte.sv
// inv_mixcolumn_subbyte: iterative InvSubBytes(InvMixColumns(state)) with valid/ready handshakes; INV_MC_SKIP_EN adds skip_mix bypass
module inv_mixcolumn_subbyte #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
`ifdef INV_MC_SKIP_EN
  ,
  input  logic         skip_mix
`endif
);
  localparam int GROUPS = 4 / COLS_PER_CYCLE;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end
  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] work_q, work_d;
  logic [127:0] out_q, out_d;
  logic         skip_q, skip_d;
  logic         skip_in;
`ifdef INV_MC_SKIP_EN
  assign skip_in = skip_mix;
`else
  assign skip_in = 1'b0;
`endif
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  // k selects which of b, xt1, xt2, xt3 are summed: 0e=1110, 0b=1011, 0d=1101, 09=1001
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x1, x2, x3;
    x1 = xt(b);
    x2 = xt(x1);
    x3 = xt(x2);
    return (k[3] ? x3 : 8'h00) ^ (k[2] ? x2 : 8'h00) ^ (k[1] ? x1 : 8'h00) ^ (k[0] ? b : 8'h00);
  endfunction
  // Inverse S-box: high nibble picks a row, low nibble picks the byte (entry 0 in the row MSB)
  function automatic logic [7:0] isb(input logic [7:0] b);
    logic [127:0] r;
    case (b[7:4])
      4'h0:    r = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1:    r = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2:    r = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3:    r = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4:    r = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5:    r = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6:    r = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7:    r = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8:    r = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9:    r = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha:    r = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb:    r = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc:    r = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd:    r = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he:    r = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      default: r = 128'h172b047eba77d626e169146355210c7d;
    endcase
    return r[{~b[3:0], 3'd0} +: 8];
  endfunction
  // One column: row i uses coefficients 0e,0b,0d,09 rotated right by i
  function automatic logic [31:0] inv_col(input logic [31:0] c, input logic skip);
    logic [7:0]  b [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) b[i] = c[31-8*i -: 8];
    r = '0;
    for (int i = 0; i < 4; i++)
      r[31-8*i -: 8] = isb(skip ? b[i] : gmul(b[i], 4'he) ^ gmul(b[2'(i+1)], 4'hb) ^
                                          gmul(b[2'(i+2)], 4'hd) ^ gmul(b[2'(i+3)], 4'h9));
    return r;
  endfunction
  // Column c lives at bits [(3-c)*32 +: 32]
  function automatic logic [6:0] col_lsb(input logic [1:0] cnt, input int k);
    return {~(2'(int'(cnt) * COLS_PER_CYCLE + k)), 5'd0};
  endfunction
  // Next state: capture in IDLE, transform one column group per BUSY cycle in place, hold in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    skip_d  = skip_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = BUSY;
        cnt_d   = '0;
        work_d  = in_state;
        skip_d  = skip_in;
      end
      BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++)
          work_d[col_lsb(cnt_q, k) +: 32] = inv_col(work_q[col_lsb(cnt_q, k) +: 32], skip_q);
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(GROUPS - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          out_d   = work_d;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      skip_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      skip_q  <= skip_d;
      out_q   <= out_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_state = out_q;
endmodule
